// File: rtl/hypercorex_inst_pkg.sv
// hypercorex_inst_pkg
// Shared definitions for the instruction sequencer: the sequencer state type
// and the default instruction-memory depth and loop-counter width.
// No ports (package).

package hypercorex_inst_pkg;

  localparam int unsigned DefInstMemDepth = 128;
  localparam int unsigned DefLoopCntWidth = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } seq_state_e;

endpackage

// File: rtl/inst_loop_cnt.sv
// inst_loop_cnt
// Loop bookkeeping for the instruction sequencer: holds the captured loop
// bounds and count, checks that the loop range is usable, and tracks the
// current iteration. Raises o_jump when the current handshake should branch
// back to the loop start instead of advancing linearly.
// Optional feature macro: HYPERCOREX_INST_LOOP_EN. Without it no loop state
// exists, o_jump is 0 and o_loop_iter is 0.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   i_capture             start accepted: load cfg, clear iteration
//   i_clear               program left RUN: clear iteration
//   i_advance             handshake accepted this cycle
//   i_addr                current instruction address
//   i_prog_end            captured last program address
//   i_cfg_loop_start/end  loop body bounds (sampled on i_capture)
//   i_cfg_loop_count      loop body executions (sampled on i_capture)
//   o_jump                branch to o_loop_start on this handshake
//   o_loop_start          captured loop start address
//   o_loop_iter           current 0-based iteration

module inst_loop_cnt #(
  parameter int unsigned AddrWidth    = 7,
  parameter int unsigned LoopCntWidth = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    i_capture,
  input  logic                    i_clear,
  input  logic                    i_advance,
  input  logic [AddrWidth-1:0]    i_addr,
  input  logic [AddrWidth-1:0]    i_prog_end,
  input  logic [AddrWidth-1:0]    i_cfg_loop_start,
  input  logic [AddrWidth-1:0]    i_cfg_loop_end,
  input  logic [LoopCntWidth-1:0] i_cfg_loop_count,
  output logic                    o_jump,
  output logic [AddrWidth-1:0]    o_loop_start,
  output logic [LoopCntWidth-1:0] o_loop_iter
);

`ifdef HYPERCOREX_INST_LOOP_EN
  logic [AddrWidth-1:0]    r_loop_start;
  logic [AddrWidth-1:0]    r_loop_end;
  logic [LoopCntWidth-1:0] r_loop_count;
  logic [LoopCntWidth-1:0] r_loop_iter;
  logic                    w_enable;
  logic                    w_jump;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_loop_start <= '0;
      r_loop_end   <= '0;
      r_loop_count <= '0;
      r_loop_iter  <= '0;
    end else if (i_capture) begin
      r_loop_start <= i_cfg_loop_start;
      r_loop_end   <= i_cfg_loop_end;
      r_loop_count <= i_cfg_loop_count;
      r_loop_iter  <= '0;
    end else if (i_clear) begin
      r_loop_iter  <= '0;
    end else if (i_advance && w_jump) begin
      r_loop_iter  <= r_loop_iter + LoopCntWidth'(1);
    end
  end

  // Counts of 0/1 mean a single pass; a bad range means straight-line code.
  assign w_enable = (r_loop_start <= r_loop_end) && (r_loop_end <= i_prog_end) &&
                    (r_loop_count >= LoopCntWidth'(2));

  // count >= 2 whenever enabled, so count-1 cannot underflow here.
  assign w_jump = w_enable && (i_addr == r_loop_end) &&
                  (r_loop_iter < (r_loop_count - LoopCntWidth'(1)));

  assign o_jump       = w_jump;
  assign o_loop_start = r_loop_start;
  assign o_loop_iter  = r_loop_iter;
`else
  logic w_unused_loop_in;

  assign w_unused_loop_in = ^{clk_i, rst_i, i_capture, i_clear, i_advance, i_addr, i_prog_end,
                              i_cfg_loop_start, i_cfg_loop_end, i_cfg_loop_count};

  assign o_jump       = 1'b0;
  assign o_loop_start = '0;
  assign o_loop_iter  = '0;
`endif

endmodule

// File: rtl/inst_seq_ctrl.sv
// inst_seq_ctrl
// Instruction sequencer: on start, walks instruction addresses 0..prog_end
// with a valid/ready handshake, optionally repeating one loop body, then
// pulses done for one cycle. stop aborts silently back to IDLE.
// Optional feature macro: HYPERCOREX_INST_LOOP_EN (loop support).
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   start_i, stop_i              one-cycle start request, abort request
//   cfg_prog_end_addr_i          last program address
//   cfg_loop_start/end_addr_i    loop body bounds
//   cfg_loop_count_i             loop body executions
//   inst_addr_o, inst_valid_o    instruction address and its valid
//   inst_ready_i                 datapath accepts the current address
//   loop_iter_o                  current 0-based loop iteration
//   busy_o, done_o               in RUN, one-cycle completion pulse

module inst_seq_ctrl
  import hypercorex_inst_pkg::*;
#(
  parameter int unsigned InstMemDepth = DefInstMemDepth,
  parameter int unsigned LoopCntWidth = DefLoopCntWidth,
  localparam int unsigned AddrWidth   = $clog2(InstMemDepth)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic [AddrWidth-1:0]    cfg_prog_end_addr_i,
  input  logic [AddrWidth-1:0]    cfg_loop_start_addr_i,
  input  logic [AddrWidth-1:0]    cfg_loop_end_addr_i,
  input  logic [LoopCntWidth-1:0] cfg_loop_count_i,
  output logic [AddrWidth-1:0]    inst_addr_o,
  output logic                    inst_valid_o,
  input  logic                    inst_ready_i,
  output logic [LoopCntWidth-1:0] loop_iter_o,
  output logic                    busy_o,
  output logic                    done_o
);

  seq_state_e           r_state;
  seq_state_e           w_state_next;
  logic [AddrWidth-1:0] r_addr;
  logic [AddrWidth-1:0] r_prog_end;
  logic [AddrWidth-1:0] w_loop_start;
  logic                 w_start;
  logic                 w_stop;
  logic                 w_advance;
  logic                 w_clear;
  logic                 w_jump;
  logic                 w_at_end;

  assign w_start   = (r_state == StIdle) & start_i;
  assign w_stop    = (r_state == StRun) & stop_i;
  // stop wins over a same-cycle handshake.
  assign w_advance = (r_state == StRun) & inst_ready_i & ~stop_i;
  assign w_clear   = w_stop | (r_state == StDone);
  assign w_at_end  = (r_addr == r_prog_end);

  inst_loop_cnt #(
    .AddrWidth    (AddrWidth),
    .LoopCntWidth (LoopCntWidth)
  ) u_loop_cnt (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .i_capture        (w_start),
    .i_clear          (w_clear),
    .i_advance        (w_advance),
    .i_addr           (r_addr),
    .i_prog_end       (r_prog_end),
    .i_cfg_loop_start (cfg_loop_start_addr_i),
    .i_cfg_loop_end   (cfg_loop_end_addr_i),
    .i_cfg_loop_count (cfg_loop_count_i),
    .o_jump           (w_jump),
    .o_loop_start     (w_loop_start),
    .o_loop_iter      (loop_iter_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (start_i) w_state_next = StRun;
      StRun: begin
        if (stop_i) begin
          w_state_next = StIdle;
        end else if (w_advance && !w_jump && w_at_end) begin
          w_state_next = StDone;
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr     <= '0;
      r_prog_end <= '0;
    end else begin
      if (w_start) begin
        r_prog_end <= cfg_prog_end_addr_i;
      end
      if (w_start || w_clear) begin
        r_addr <= '0;
      end else if (w_advance) begin
        if (w_jump) begin
          r_addr <= w_loop_start;
        end else if (!w_at_end) begin
          r_addr <= r_addr + AddrWidth'(1);
        end
      end
    end
  end

  always_comb begin
    inst_valid_o = (r_state == StRun);
    busy_o       = (r_state == StRun);
    done_o       = (r_state == StDone);
    inst_addr_o  = r_addr;
  end

endmodule

// File: tb/tb_inst_seq_ctrl.sv
module tb_inst_seq_ctrl;

  localparam int unsigned AW = 7;
  localparam int unsigned CW = 16;

  typedef struct packed {
    logic [AW-1:0]       prog_end;
    logic [AW-1:0]       loop_start;
    logic [AW-1:0]       loop_end;
    logic [CW-1:0]       count;
    logic [4:0]          len;
    logic [0:11][AW-1:0] exp_addr;
    logic [0:11][3:0]    exp_iter;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_i, start_i, stop_i, inst_ready_i;
  logic [AW-1:0] cfg_prog_end_addr_i, cfg_loop_start_addr_i, cfg_loop_end_addr_i;
  logic [CW-1:0] cfg_loop_count_i;
  logic [AW-1:0] inst_addr_o;
  logic          inst_valid_o, busy_o, done_o;
  logic [CW-1:0] loop_iter_o;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[7];

  always #5 clk = ~clk;

  inst_seq_ctrl #(
    .InstMemDepth (128),
    .LoopCntWidth (CW)
  ) dut (
    .clk_i                 (clk),
    .rst_i                 (rst_i),
    .start_i               (start_i),
    .stop_i                (stop_i),
    .cfg_prog_end_addr_i   (cfg_prog_end_addr_i),
    .cfg_loop_start_addr_i (cfg_loop_start_addr_i),
    .cfg_loop_end_addr_i   (cfg_loop_end_addr_i),
    .cfg_loop_count_i      (cfg_loop_count_i),
    .inst_addr_o           (inst_addr_o),
    .inst_valid_o          (inst_valid_o),
    .inst_ready_i          (inst_ready_i),
    .loop_iter_o           (loop_iter_o),
    .busy_o                (busy_o),
    .done_o                (done_o)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [AW-1:0] pe, input logic [AW-1:0] ls,
                              input logic [AW-1:0] le, input logic [CW-1:0] cnt,
                              input logic [4:0] len, input logic [0:11][AW-1:0] addr,
                              input logic [0:11][3:0] iter);
    vec_t v;
    v.prog_end   = pe;
    v.loop_start = ls;
    v.loop_end   = le;
    v.count      = cnt;
    v.len        = len;
    v.exp_addr   = addr;
    v.exp_iter   = iter;
    return v;
  endfunction

  task automatic set_cfg(input logic [AW-1:0] pe, input logic [AW-1:0] ls,
                         input logic [AW-1:0] le, input logic [CW-1:0] cnt);
    cfg_prog_end_addr_i   = pe;
    cfg_loop_start_addr_i = ls;
    cfg_loop_end_addr_i   = le;
    cfg_loop_count_i      = cnt;
  endtask

  // Runs one table vector with ready held high. With disturb set, start and
  // new cfg values are driven mid-run, and start/stop are driven during DONE.
  task automatic run_vec(input int idx, input bit disturb);
    vec_t v;
    v = vecs[idx];
    @(negedge clk);
    set_cfg(v.prog_end, v.loop_start, v.loop_end, v.count);
    start_i      = 1'b1;
    inst_ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < int'(v.len); i++) begin
      check($sformatf("v%0d addr[%0d]", idx, i), 32'(inst_addr_o), 32'(v.exp_addr[i]));
      check($sformatf("v%0d iter[%0d]", idx, i), 32'(loop_iter_o), 32'(v.exp_iter[i]));
      check($sformatf("v%0d valid/busy/done[%0d]", idx, i),
            32'({inst_valid_o, busy_o, done_o}), 32'(3'b110));
      if (disturb && i == 1) begin
        start_i = 1'b1;
        set_cfg(7'd2, 7'd0, 7'd0, 16'd0);
      end
      if (disturb && i == 2) start_i = 1'b0;
      @(negedge clk);
    end
    check($sformatf("v%0d done cycle", idx), 32'({inst_valid_o, busy_o, done_o}), 32'(3'b001));
    if (disturb) begin
      start_i = 1'b1;
      stop_i  = 1'b1;
    end
    @(negedge clk);
    start_i = 1'b0;
    stop_i  = 1'b0;
    check($sformatf("v%0d idle after done", idx),
          32'({inst_valid_o, busy_o, done_o}), 32'(3'b000));
    check($sformatf("v%0d idle addr", idx), 32'(inst_addr_o), 32'd0);
  endtask

  task automatic wait_done(input string name, input int max_cycles);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < max_cycles && !seen; k++) begin
      if (done_o) seen = 1'b1;
      else @(negedge clk);
    end
    check({name, " done seen"}, 32'(done_o), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    logic [0:11][3:0] zi;
    bit               found;
    zi = '0;

    vecs[0] = mk(7'd3, 7'd2, 7'd1, 16'd5, 5'd4,
                 {7'd0, 7'd1, 7'd2, 7'd3, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0}, zi);
`ifdef HYPERCOREX_INST_LOOP_EN
    vecs[1] = mk(7'd5, 7'd1, 7'd2, 16'd3, 5'd10,
                 {7'd0, 7'd1, 7'd2, 7'd1, 7'd2, 7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd0, 7'd0},
                 {4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd0, 4'd0});
    vecs[6] = mk(7'd3, 7'd2, 7'd2, 16'd2, 5'd5,
                 {7'd0, 7'd1, 7'd2, 7'd2, 7'd3, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0},
                 {4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0});
`else
    vecs[1] = mk(7'd5, 7'd1, 7'd2, 16'd3, 5'd6,
                 {7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0}, zi);
    vecs[6] = mk(7'd3, 7'd2, 7'd2, 16'd2, 5'd4,
                 {7'd0, 7'd1, 7'd2, 7'd3, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0}, zi);
`endif
    vecs[2] = mk(7'd4, 7'd1, 7'd2, 16'd0, 5'd5,
                 {7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0}, zi);
    vecs[3] = mk(7'd4, 7'd1, 7'd2, 16'd1, 5'd5,
                 {7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0}, zi);
    vecs[4] = mk(7'd3, 7'd1, 7'd4, 16'd3, 5'd4,
                 {7'd0, 7'd1, 7'd2, 7'd3, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0}, zi);
    vecs[5] = mk(7'd0, 7'd0, 7'd0, 16'd0, 5'd1, '0, zi);

    rst_i        = 1'b1;
    start_i      = 1'b0;
    stop_i       = 1'b0;
    inst_ready_i = 1'b0;
    set_cfg(7'd0, 7'd0, 7'd0, 16'd0);
    repeat (2) @(negedge clk);
    check("reset addr", 32'(inst_addr_o), 32'd0);
    check("reset iter", 32'(loop_iter_o), 32'd0);
    check("reset valid/busy/done", 32'({inst_valid_o, busy_o, done_o}), 32'(3'b000));
    rst_i  = 1'b0;
    // stop in IDLE does nothing
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    check("stop in idle", 32'({inst_valid_o, busy_o, done_o, inst_addr_o}), 32'd0);

    for (int n = 0; n < 7; n++) run_vec(n, 1'b0);

    // Stall at address 2 for three cycles.
    @(negedge clk);
    set_cfg(7'd5, 7'd0, 7'd0, 16'd0);
    start_i      = 1'b1;
    inst_ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("stall pre addr", 32'(inst_addr_o), 32'd2);
    inst_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("stall hold addr %0d", k), 32'(inst_addr_o), 32'd2);
      check($sformatf("stall hold valid %0d", k), 32'(inst_valid_o), 32'd1);
    end
    inst_ready_i = 1'b1;
    @(negedge clk);
    check("stall release addr", 32'(inst_addr_o), 32'd3);
    wait_done("stall", 20);

    // Stop coinciding with a handshake at address 2, then restart.
    @(negedge clk);
    set_cfg(7'd5, 7'd0, 7'd0, 16'd0);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("stop pre addr", 32'(inst_addr_o), 32'd2);
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    check("stop idle flags", 32'({inst_valid_o, busy_o, done_o}), 32'(3'b000));
    check("stop idle addr", 32'(inst_addr_o), 32'd0);
    @(negedge clk);
    check("stop no done", 32'(done_o), 32'd0);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("restart addr", 32'(inst_addr_o), 32'd0);
    check("restart valid", 32'(inst_valid_o), 32'd1);
    wait_done("restart", 20);

    // Reset at address 4 of the loop program.
    @(negedge clk);
    set_cfg(7'd5, 7'd1, 7'd2, 16'd3);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    found   = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (inst_valid_o && inst_addr_o == 7'd4) found = 1'b1;
      else @(negedge clk);
    end
    check("reached addr 4", 32'(found), 32'd1);
    rst_i = 1'b1;
    @(negedge clk);
    check("mid-run reset addr", 32'(inst_addr_o), 32'd0);
    check("mid-run reset iter", 32'(loop_iter_o), 32'd0);
    check("mid-run reset flags", 32'({inst_valid_o, busy_o, done_o}), 32'(3'b000));
    rst_i = 1'b0;
    @(negedge clk);
    check("post reset no done", 32'({busy_o, done_o}), 32'd0);

    // start and cfg changes while busy, start/stop during DONE: all ignored.
    run_vec(1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_seq_ctrl.md
INST_SEQ_CTRL -- requirements
Module: inst_seq_ctrl

Interface
REQ-001 SHALL have parameter InstMemDepth, default 128: instruction memory depth in words.
REQ-002 SHALL have parameter LoopCntWidth, default 16: loop iteration counter width.
REQ-003 SHALL define localparam AddrWidth = $clog2(InstMemDepth).
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start_i  input  1  one-cycle start request.
REQ-007 SHALL have port stop_i  input  1  abort request.
REQ-008 SHALL have port cfg_prog_end_addr_i  input  AddrWidth  last program address.
REQ-009 SHALL have port cfg_loop_start_addr_i  input  AddrWidth  first address of the loop body.
REQ-010 SHALL have port cfg_loop_end_addr_i  input  AddrWidth  last address of the loop body.
REQ-011 SHALL have port cfg_loop_count_i  input  LoopCntWidth  number of loop body executions.
REQ-012 SHALL have port inst_addr_o  output  AddrWidth  instruction memory read address.
REQ-013 SHALL have port inst_valid_o  output  1  address valid to the decoder/datapath.
REQ-014 SHALL have port inst_ready_i  input  1  datapath accepts the current instruction.
REQ-015 SHALL have port loop_iter_o  output  LoopCntWidth  current loop iteration, 0-based.
REQ-016 SHALL have port busy_o  output  1  sequencer in RUN.
REQ-017 SHALL have port done_o  output  1  one-cycle completion pulse.

Function
REQ-018 SHALL implement states IDLE, RUN and DONE.
REQ-019 SHALL, in IDLE, transition to RUN on start_i=1, with inst_addr_o=0 and loop_iter_o=0, so that inst_valid_o is 1 in the next cycle.
REQ-020 SHALL capture all cfg_* inputs into registers on the accepted start_i, and SHALL ignore cfg_* changes while in RUN.
REQ-021 SHALL ignore start_i while in RUN or DONE.
REQ-022 SHALL hold inst_valid_o=1 throughout RUN, and SHALL hold inst_addr_o stable until inst_valid_o and inst_ready_i are both 1 (a handshake).
REQ-023 SHALL advance the address on a handshake as follows: if address==loop_end, loop enabled and loop_iter < count-1, go to loop_start and increment loop_iter; otherwise, if address==prog_end, go to DONE; otherwise, add 1 to the address.
REQ-024 SHALL issue one address per cycle when inst_ready_i is held at 1 (zero-bubble throughput).
REQ-025 SHALL consider the loop enabled only when loop_start <= loop_end <= prog_end and the captured count >= 2.
REQ-026 SHALL treat a captured count of 0 or 1 as a single pass, and SHALL treat an invalid range as straight-line execution from 0 to prog_end.
REQ-027 SHALL assert done_o=1 and inst_valid_o=0 for exactly one cycle in DONE, then return to IDLE.
REQ-028 SHALL, when stop_i=1 in RUN, go to IDLE next cycle with no done_o pulse and no address advance, even if a handshake occurs in the same cycle.
REQ-029 SHALL have no effect when stop_i=1 in IDLE or DONE.
REQ-030 SHALL assert busy_o exactly when the state is RUN.
REQ-031 SHALL ensure that inst_addr_o never exceeds prog_end and that loop_iter_o never exceeds count-1.
REQ-032 SHALL execute a prog_end=0 program as a single instruction at address 0.

Reset
REQ-033 SHALL, on rst_i=1, set state to IDLE, inst_addr_o=0, loop_iter_o=0, inst_valid_o=0, busy_o=0 and done_o=0, with all cfg registers set to 0.
REQ-034 SHALL give rst_i priority over start_i and stop_i; a reset mid-RUN aborts the program with no done_o pulse.

Configuration
REQ-035 SHALL, with HYPERCOREX_INST_LOOP_EN defined, provide the loop behaviour of REQ-023, REQ-025 and REQ-026.
REQ-036 SHALL, without HYPERCOREX_INST_LOOP_EN, keep all ports, ignore cfg_loop_* inputs, tie loop_iter_o to 0, execute 0..prog_end linearly, and synthesize no loop registers.

Structure
REQ-037 SHALL take its state enum typedef from the shared instruction package (hypercorex_inst_pkg), together with default depth and counter-width constants.
REQ-038 SHALL place loop address compare and iteration counting in one sub-module, inst_loop_cnt.
REQ-039 SHALL keep the top-level FSM in inst_seq_ctrl.

Verification
REQ-040 SHALL verify: prog_end=3, loop invalid, ready=1 -> addresses 0,1,2,3 on consecutive cycles; done_o the cycle after address 3; then IDLE.
REQ-041 SHALL verify: prog_end=5, loop 1..2, count=3, ready=1 -> addresses 0,1,2,1,2,1,2,3,4,5, loop_iter_o 0,0,0,1,1,2,2,2,2,2; without the macro -> 0..5 linear.
REQ-042 SHALL verify: ready=0 for 3 cycles at address 2 -> inst_addr_o=2 and inst_valid_o=1 held; advances to 3 one cycle after ready rises.
REQ-043 SHALL verify: stop_i and a handshake in the same cycle at address 2 -> IDLE, no done_o, inst_addr_o=0; a subsequent start_i restarts at 0.
REQ-044 SHALL verify: count=0 and count=1 -> body executed once; loop_end=4 with prog_end=3 -> linear 0..3.
REQ-045 SHALL verify: rst_i at address 4 of the REQ-041 program -> all outputs at reset values next cycle; start_i while busy ignored, with cfg changed mid-RUN having no effect.
